// File: rtl/cache_line_fill_mem_if.sv
// Bus between the cache controller (master) and the line-fill memory (slave).
// CACHE_MEM_WRITE_EN adds the single-word write port.
interface cache_line_fill_mem_if #(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 4
);
  logic                          req;
  logic [ADDR_W-1:0]             addr;
  logic                          busy;
  logic                          blk_valid;
  logic [BLOCK_WORDS*DATA_W-1:0] line_out;
`ifdef CACHE_MEM_WRITE_EN
  logic                          wr_en;
  logic [ADDR_W-1:0]             wr_addr;
  logic [DATA_W-1:0]             wr_data;

  modport master (output req, addr, wr_en, wr_addr, wr_data,
                  input  busy, blk_valid, line_out);
  modport slave  (input  req, addr, wr_en, wr_addr, wr_data,
                  output busy, blk_valid, line_out);
`else
  modport master (output req, addr, input busy, blk_valid, line_out);
  modport slave  (input req, addr, output busy, blk_valid, line_out);
`endif
endinterface

// File: rtl/cache_line_fill_mem.sv
// Main-memory line-fill stage: fixed access latency, then a one-word-per-cycle burst.
// Define CACHE_MEM_WRITE_EN to compile in the single-word write port.
//
// state   | meaning
// S_IDLE  | waiting for req (or a write when the write port exists)
// S_WAIT  | access latency countdown, LATENCY cycles
// S_BURST | one word per cycle into line_buf
// S_DONE  | blk_valid pulse, line_out holds the new line
module cache_line_fill_mem #(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int LATENCY     = 4
) (
  input logic                  clk,
  input logic                  rst,
  cache_line_fill_mem_if.slave bus
);
  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] line_buf [BLOCK_WORDS];
  logic              busy_q;
  logic              valid_q;
  logic              wr_fire;

  assign rd_addr = base + ADDR_W'(idx);

`ifdef CACHE_MEM_WRITE_EN
  // Power-up contents are mem[a] = a; a word reads from the array only once written.
  logic [DATA_W-1:0]      mem [2**ADDR_W];
  logic [2**ADDR_W-1:0]   written;

  assign wr_fire = (state == S_IDLE) && bus.wr_en;

  always_ff @(posedge clk) begin
    if (wr_fire) mem[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         written <= '0;
    else if (wr_fire) written[bus.wr_addr] <= 1'b1;
  end

  assign rd_data = written[rd_addr] ? mem[rd_addr] : DATA_W'(rd_addr);
`else
  assign wr_fire = 1'b0;
  assign rd_data = DATA_W'(rd_addr);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      base    <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int i = 0; i < BLOCK_WORDS; i++) line_buf[i] <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!wr_fire && bus.req) begin
            base   <= bus.addr & ~ADDR_W'(BLOCK_WORDS - 1);
            cnt    <= CNT_W'(LATENCY - 1);
            busy_q <= 1'b1;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            idx   <= '0;
            state <= S_BURST;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_BURST: begin
          line_buf[idx] <= rd_data;
          idx           <= idx + IDX_W'(1);
          if (idx == IDX_W'(BLOCK_WORDS - 1)) begin
            valid_q <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.blk_valid = valid_q;

  for (genvar g = 0; g < BLOCK_WORDS; g++) begin : g_line
    assign bus.line_out[g*DATA_W +: DATA_W] = line_buf[g];
  end
endmodule

// File: tb/tb_cache_line_fill_mem.sv
// Bench for cache_line_fill_mem: directed fills with literal lines, then random traffic
// against a timeline model. Build with CACHE_MEM_WRITE_EN to exercise the write port.
module tb_cache_line_fill_mem;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int BW     = 4;
  localparam int LAT    = 4;
  localparam int LW     = BW * DATA_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cache_line_fill_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLOCK_WORDS(BW)) bus ();

  cache_line_fill_mem #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLOCK_WORDS(BW), .LATENCY(LAT)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
  endtask

  // Model: a fill is a timeline of edges after the accepting edge (t=0).
  // Word k lands at edge LAT+1+k, valid at LAT+BW, back to idle at LAT+BW+1.
  int              t = -1;
  int              m_base = 0;
  logic            exp_busy = 1'b0;
  logic            exp_valid = 1'b0;
  logic [LW-1:0]   exp_line = '0;
`ifdef CACHE_MEM_WRITE_EN
  logic [DATA_W-1:0] wmem [int];
`endif

  function automatic logic [DATA_W-1:0] memval(input int a);
`ifdef CACHE_MEM_WRITE_EN
    if (wmem.exists(a)) return wmem[a];
`endif
    return DATA_W'(a);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      t = -1; exp_busy = 1'b0; exp_valid = 1'b0; exp_line = '0;
`ifdef CACHE_MEM_WRITE_EN
      wmem.delete();
`endif
    end else if (t < 0) begin
      exp_valid = 1'b0;
`ifdef CACHE_MEM_WRITE_EN
      if (bus.wr_en) wmem[int'(bus.wr_addr)] = bus.wr_data;
      else
`endif
      if (bus.req) begin
        t = 0;
        m_base = int'(bus.addr) / BW * BW;
        exp_busy = 1'b1;
      end
    end else begin
      t++;
      if (t >= LAT + 1 && t <= LAT + BW)
        exp_line[(t-LAT-1)*DATA_W +: DATA_W] = memval(m_base + t - LAT - 1);
      exp_valid = (t == LAT + BW);
      if (t == LAT + BW + 1) begin
        t = -1;
        exp_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", LW'(bus.busy), '0);
      chk("rst_valid", LW'(bus.blk_valid), '0);
      chk("rst_line", bus.line_out, '0);
    end else begin
      chk("busy", LW'(bus.busy), LW'(exp_busy));
      chk("blk_valid", LW'(bus.blk_valid), LW'(exp_valid));
      chk("line_out", bus.line_out, exp_line);
    end
  end

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(output int e);
    e = 0;
    do begin edge1(); e++; end while (!bus.blk_valid && e < 40);
    chk("valid_seen", LW'(bus.blk_valid), LW'(1));
  endtask

  task automatic fetch(input int a, output int e);
    bus.req = 1'b1; bus.addr = ADDR_W'(a);
    edge1();
    bus.req = 1'b0;
    chk("busy_after_accept", LW'(bus.busy), LW'(1));
    wait_valid(e);
  endtask

  initial begin
    int e;
    bus.req = 1'b0; bus.addr = '0;
`ifdef CACHE_MEM_WRITE_EN
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
`endif
    #1 rst_n = 1'b0;
    repeat (2) edge1();
    chk("reset_busy", LW'(bus.busy), '0);
    chk("reset_line", bus.line_out, '0);
    rst_n = 1'b1;
    repeat (2) edge1();
    chk("idle_no_req", LW'(bus.busy), '0);

    fetch(1024, e);
    chk("fetch_latency", LW'(e), LW'(8));
    chk("line_1024", bus.line_out, {32'd1027, 32'd1026, 32'd1025, 32'd1024});
    edge1();
    chk("valid_one_cycle", LW'(bus.blk_valid), '0);
    chk("line_held", bus.line_out, {32'd1027, 32'd1026, 32'd1025, 32'd1024});
    edge1();

    fetch(1030, e);
    chk("line_1030", bus.line_out, {32'd1031, 32'd1030, 32'd1029, 32'd1028});
    repeat (2) edge1();
    fetch(32767, e);
    chk("line_top", bus.line_out, {32'd32767, 32'd32766, 32'd32765, 32'd32764});
    repeat (2) edge1();

    bus.req = 1'b1; bus.addr = ADDR_W'(1024);
    edge1();
    repeat (3) edge1();
    bus.addr = ADDR_W'(5000);
    wait_valid(e);
    chk("held_first_line", bus.line_out, {32'd1027, 32'd1026, 32'd1025, 32'd1024});
    wait_valid(e);
    bus.req = 1'b0;
    chk("held_gap", LW'(e), LW'(10));
    chk("held_second_line", bus.line_out, {32'd5003, 32'd5002, 32'd5001, 32'd5000});
    repeat (3) edge1();
    chk("held_dropped_idle", LW'(bus.busy), '0);

    bus.req = 1'b1; bus.addr = ADDR_W'(2048);
    edge1();
    bus.req = 1'b0;
    repeat (LAT + 2) edge1();
    rst_n = 1'b0;
    #1;
    chk("midburst_busy", LW'(bus.busy), '0);
    chk("midburst_valid", LW'(bus.blk_valid), '0);
    chk("midburst_line", bus.line_out, '0);
    repeat (2) edge1();
    rst_n = 1'b1;
    edge1();
    fetch(2048, e);
    chk("refetch_latency", LW'(e), LW'(8));
    chk("refetch_line", bus.line_out, {32'd2051, 32'd2050, 32'd2049, 32'd2048});
    repeat (2) edge1();

`ifdef CACHE_MEM_WRITE_EN
    bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(1025); bus.wr_data = 32'hDEADBEEF;
    bus.req = 1'b1; bus.addr = ADDR_W'(1024);
    edge1();
    bus.wr_en = 1'b0;
    chk("write_wins_idle", LW'(bus.busy), '0);
    edge1();
    bus.req = 1'b0;
    chk("fetch_after_write", LW'(bus.busy), LW'(1));
    wait_valid(e);
    chk("write_fetch_latency", LW'(e), LW'(8));
    chk("write_fetch_line", bus.line_out, {32'd1027, 32'd1026, 32'hDEADBEEF, 32'd1024});
    repeat (2) edge1();
`endif

    repeat (3000) begin
      edge1();
      rst_n    = ($urandom_range(0, 249) != 0);
      bus.req  = ($urandom_range(0, 2) == 0);
      bus.addr = ($urandom_range(0, 3) == 0) ? ADDR_W'(32764 + $urandom_range(0, 3))
                                              : ADDR_W'($urandom);
`ifdef CACHE_MEM_WRITE_EN
      bus.wr_en   = ($urandom_range(0, 3) == 0);
      bus.wr_addr = ($urandom_range(0, 1) == 0) ? (bus.addr ^ ADDR_W'($urandom_range(0, 3)))
                                                 : ADDR_W'($urandom);
      bus.wr_data = $urandom;
`endif
    end
    rst_n = 1'b1; bus.req = 1'b0;
`ifdef CACHE_MEM_WRITE_EN
    bus.wr_en = 1'b0;
`endif
    repeat (20) edge1();
    chk("final_idle", LW'(bus.busy), '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cache_line_fill_mem.md
Name: cache_line_fill_mem

Overview:
- Main-memory stage directly downstream of the cache controller; services line fills on every cache miss.
- Accepts a block-fill request with a 15-bit word address and waits a fixed access latency.
- Then reads the block one word per cycle into a line buffer and returns the whole line with a one-cycle valid pulse.
- Read-only by default. An optional single-word write port can be compiled in.

Parameters:
- ADDR_W, 15: word-address width; memory depth is 2^ADDR_W words.
- DATA_W, 32: word width in bits.
- BLOCK_WORDS, 4: words per cache line; must be a power of 2 and at least 2.
- LATENCY, 4: access-latency cycles before the burst starts; must be at least 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-low; the block is in reset while rst=0.
- req  in  1  fill request; level-sensitive; sampled only in IDLE.
- addr  in  ADDR_W  miss address; any word inside the wanted block.
- busy  out  1  high in every state other than IDLE.
- blk_valid  out  1  one-cycle pulse; line_out holds a new line.
- line_out  out  BLOCK_WORDS*DATA_W  filled line; word i is at bits [i*DATA_W +: DATA_W], so word 0 is in the LSBs.

Behaviour:
- Memory contents at time 0: mem[a] = a, zero-extended to DATA_W.
- Reset (rst=0, asynchronous):
  - state=IDLE; busy=0, blk_valid=0, line_out=0.
  - Latency counter, word index and base register all cleared.
  - Reset applies immediately, even mid-WAIT or mid-BURST. No partial line is ever flagged valid.
- IDLE:
  - If req=1 at a rising edge, latch base = addr with its low log2(BLOCK_WORDS) bits cleared.
  - Load cnt=LATENCY-1 and go to WAIT.
  - If req=0, stay in IDLE.
- WAIT:
  - If cnt=0, go to BURST with idx=0; otherwise decrement cnt.
  - WAIT lasts exactly LATENCY cycles.
- BURST:
  - At each edge, line_buf[idx] <= mem[base+idx] and idx increments.
  - After word BLOCK_WORDS-1 is written, go to DONE.
  - idx is log2(BLOCK_WORDS) bits wide. base+idx never crosses the block, so there is no address wrap; the top block (32764..32767 by default) is legal.
- DONE:
  - blk_valid=1 for exactly one cycle, then go to IDLE.
  - line_out is driven from line_buf. It stays stable from the DONE cycle until overwritten by the next burst; it is not cleared on return to IDLE.
- Latency: blk_valid rises at the (LATENCY+BLOCK_WORDS)-th rising edge after the accepting edge (8 edges with the defaults).
- Request handling:
  - req and addr changes while busy=1 are ignored; there is no queue.
  - The address is captured only at the accepting edge.
  - If req is still 1 in the IDLE cycle after DONE, a new fetch starts at that edge. The cache must drop req once it sees blk_valid.
- Outputs are registered: busy and blk_valid are derived from the state register and have no combinational path from req.

Optional Feature:
- Macro: CACHE_MEM_WRITE_EN.
- With the macro defined, three extra ports exist: wr_en (in, 1), wr_addr (in, ADDR_W), wr_data (in, DATA_W).
  - In IDLE, wr_en=1 writes mem[wr_addr] <= wr_data at the edge and takes priority over req.
  - The colliding req is serviced no earlier than the next IDLE edge.
  - wr_en is ignored while busy=1.
  - Write-then-fetch of the same word returns the new value.
- Without the macro, the ports are absent and the memory is read-only.

Test Plan:
1. Reset: hold rst=0 for 2 cycles -> busy=0, blk_valid=0, line_out=0; state stays IDLE with req=0.
2. Fetch: req=1, addr=1024 for one cycle -> busy=1 from the next edge; blk_valid high for exactly 1 cycle at edge +8; line_out = {1027,1026,1025,1024}, word 0 in the LSBs.
3. Alignment and top of memory: addr=1030 -> line {1031,1030,1029,1028}. addr=32767 -> line {32767,32766,32765,32764}.
4. Busy and held request: during a fetch of 1024, change addr to 5000 with req held high -> first line is 1024..1027. A second fetch of block 5000..5003 starts at the IDLE edge after DONE, and a second blk_valid arrives 8 edges later.
5. Reset mid-burst: assert rst=0 after 2 burst words -> immediate IDLE, busy=0, no blk_valid, line_out=0. Refetch of 2048 then returns 2048..2051 normally.
6. With CACHE_MEM_WRITE_EN: wr_en=1, wr_addr=1025, wr_data=32'hDEADBEEF together with req=1, addr=1024 -> write wins; the fetch follows. Line = {1027,1026,32'hDEADBEEF,1024}.
